// File: rtl/pulse_counter_pkg.sv
// Shared types and default widths for the pulse_counter path.
package pulse_counter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } pc_state_t;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GATE_W = 24;

endpackage

// File: rtl/pulse_gate_timer.sv
// Loadable down-counter; o_last marks the final cycle of a gate window.
module pulse_gate_timer #(
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [GATE_W-1:0] i_len,
    input  logic              i_en,
    output logic              o_last
);

    logic [GATE_W-1:0] r_cnt;

    // Load wins over decrement so a back-to-back window reloads on its last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - GATE_W'(1);
        end
    end

    assign o_last = i_en && (r_cnt == GATE_W'(1));

endmodule

// File: rtl/pulse_window_counter.sv
// Counts i_edge pulses over a programmable gate window; single-shot or continuous.
// Optional build macro PULSE_CNT_SAT_EN: saturate the count instead of wrapping.
import pulse_counter_pkg::*;

module pulse_window_counter #(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_edge,
    input  logic              i_start,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic              i_continuous,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_valid,
    output logic              o_ovf
);

    pc_state_t         r_state;
    logic [GATE_W-1:0] r_gate_len;
    logic [CNT_W-1:0]  r_acc;
    logic              r_ovf_acc;
    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [GATE_W-1:0] w_load_len;
    logic              w_all_ones;
    logic [CNT_W-1:0]  w_acc_next;
    logic              w_ovf_next;

    assign w_accept   = (r_state == ST_IDLE) && i_start && (i_gate_len != '0);
    assign w_load     = w_accept || (w_last && i_continuous);
    assign w_load_len = w_accept ? i_gate_len : r_gate_len;
    assign w_all_ones = &r_acc;

    pulse_gate_timer #(
        .GATE_W (GATE_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_len  (w_load_len),
        .i_en   (r_state == ST_COUNT),
        .o_last (w_last)
    );

    // Overflow is flagged on the increment attempted from all-ones.
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf_acc;
        if (i_edge) begin
`ifdef PULSE_CNT_SAT_EN
            if (w_all_ones) begin
                w_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + CNT_W'(1);
            end
`else
            w_acc_next = r_acc + CNT_W'(1);
            if (w_all_ones) begin
                w_ovf_next = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gate_len <= '0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gate_len <= i_gate_len;
                        r_acc      <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_last) begin
                        r_count   <= w_acc_next;
                        r_ovf     <= w_ovf_next;
                        r_valid   <= 1'b1;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        if (!i_continuous) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_acc     <= w_acc_next;
                        r_ovf_acc <= w_ovf_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;

endmodule
